// File: rtl/expr_tx_pkg.sv
// expr_tx_pkg: types, operator codes and ASCII constants shared across the
// expression transmitter.
//   state_t      : transmitter FSM states
//   OP_*         : 2-bit operator codes as seen on the ops input
//   ASCII_*      : character codes put on the output bus
//   op_to_ascii  : operator code -> ASCII operator character
//   digit_ascii  : BCD digit -> ASCII digit character
package expr_tx_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_DIG = 2'd1,
    SEND_OP  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  function automatic logic [7:0] op_to_ascii(input logic [1:0] op);
    case (op)
      OP_ADD:  op_to_ascii = ASCII_PLUS;
      OP_SUB:  op_to_ascii = ASCII_MINUS;
      OP_MUL:  op_to_ascii = ASCII_STAR;
      OP_DIV:  op_to_ascii = ASCII_SLASH;
      default: op_to_ascii = ASCII_PLUS;
    endcase
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    digit_ascii = ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/expr_tx_validate.sv
// expr_tx_validate: combinational acceptance check for a load request.
//   count  : number of operands requested
//   digits : packed BCD operands, operand i at [4i+3:4i]
//   ok     : 1 when count is within 1..MAX_OPERANDS and every operand below
//            count is a decimal digit; operands beyond count are don't-care
module expr_tx_validate #(
  parameter int MAX_OPERANDS = 8
) (
  input  logic [3:0]                count,
  input  logic [4*MAX_OPERANDS-1:0] digits,
  output logic                      ok
);

  always_comb begin
    ok = (count != 4'd0) && (int'(count) <= MAX_OPERANDS);
    for (int i = 0; i < MAX_OPERANDS; i++) begin
      if ((i < int'(count)) && (digits[4*i +: 4] > 4'd9)) ok = 1'b0;
    end
  end

endmodule

// File: rtl/expr_tx.sv
// expr_tx: serialises a snapshot of operands and operators as the ASCII
// expression digit, op, digit, ..., digit over a valid/ready byte stream.
//   clk, clr   : clock (rising edge), asynchronous active-high reset
//   start      : load request, honoured only while idle
//   count      : number of operands N (1..MAX_OPERANDS)
//   digits     : packed BCD operands, operand i at [4i+3:4i]
//   ops        : packed operators, operator i at [2i+1:2i], between operand
//                i and operand i+1
//   out_char   : registered ASCII character
//   out_valid  : registered, out_char is meaningful
//   out_ready  : sink accepts out_char this cycle
//   busy       : a stream is in progress
//   done       : one-cycle pulse after the last digit is taken
//   err        : one-cycle pulse after a rejected load request
module expr_tx
  import expr_tx_pkg::*;
#(
  parameter int MAX_OPERANDS = 8
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          start,
  input  logic [3:0]                    count,
  input  logic [4*MAX_OPERANDS-1:0]     digits,
  input  logic [2*(MAX_OPERANDS-1)-1:0] ops,
  output logic [7:0]                    out_char,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          err
);

  state_t state, state_nx;

  // Snapshot shift registers: the current operand/operator always sits in
  // the low bits, so no explicit index is needed.
  logic [4*MAX_OPERANDS-1:0]     dig_sr;
  logic [2*(MAX_OPERANDS-1)-1:0] op_sr;
  logic [4:0]                    rem, rem_nx;

  logic       ok, xfer, last;
  logic       ld, shift_dig, shift_op;
  logic [7:0] char_nx;
  logic       valid_nx, done_nx, err_nx;

  expr_tx_validate #(.MAX_OPERANDS(MAX_OPERANDS)) u_validate (
    .count  (count),
    .digits (digits),
    .ok     (ok)
  );

  assign xfer = out_valid && out_ready;
  assign last = (rem == 5'd1);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start && ok) state_nx = SEND_DIG;
      SEND_DIG: if (xfer)        state_nx = last ? IDLE : SEND_OP;
      SEND_OP:  if (xfer)        state_nx = SEND_DIG;
      default:                   state_nx = IDLE;
    endcase
  end

  // Outputs are computed one cycle ahead and registered below, so out_char
  // and out_valid come straight from flops and hold during stalls.
  always_comb begin
    char_nx   = out_char;
    valid_nx  = out_valid;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    ld        = 1'b0;
    shift_dig = 1'b0;
    shift_op  = 1'b0;
    rem_nx    = rem;
    case (state)
      IDLE: begin
        if (start) begin
          if (ok) begin
            ld       = 1'b1;
            valid_nx = 1'b1;
            char_nx  = digit_ascii(digits[3:0]);
            rem_nx   = {1'b0, count};
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      SEND_DIG: begin
        if (xfer) begin
          if (last) begin
            valid_nx = 1'b0;
            char_nx  = 8'h00;
            done_nx  = 1'b1;
            rem_nx   = 5'd0;
          end else begin
            char_nx   = op_to_ascii(op_sr[1:0]);
            shift_dig = 1'b1;
            rem_nx    = rem - 5'd1;
          end
        end
      end
      SEND_OP: begin
        if (xfer) begin
          // dig_sr was already shifted when the previous digit left.
          char_nx  = digit_ascii(dig_sr[3:0]);
          shift_op = 1'b1;
        end
      end
      default: begin
        valid_nx = 1'b0;
        char_nx  = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      out_char  <= 8'h00;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rem       <= 5'd0;
    end else begin
      out_char  <= char_nx;
      out_valid <= valid_nx;
      done      <= done_nx;
      err       <= err_nx;
      rem       <= rem_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (ld) begin
      dig_sr <= digits;
      op_sr  <= ops;
    end else begin
      if (shift_dig) dig_sr <= dig_sr >> 4;
      if (shift_op)  op_sr  <= op_sr >> 2;
    end
  end

endmodule

// File: tb/tb_expr_tx.sv
module tb_expr_tx;
  localparam int M = 8;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   count = 4'd0;
  logic [31:0]  digits = '0;
  logic [13:0]  ops = '0;
  logic [7:0]   out_char;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         busy, done, err;

  expr_tx #(.MAX_OPERANDS(M)) dut (
    .clk(clk), .clr(clr), .start(start), .count(count), .digits(digits),
    .ops(ops), .out_char(out_char), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int exp_done = 0, done_cnt = 0;
  int exp_err = 0, err_cnt = 0;
  bit bp_mode = 0;
  bit expect_digit = 1;
  bit held = 0;
  logic [7:0] held_char;
  logic [7:0] exp_q[$];
  logic [7:0] rx[$];
  logic [7:0] ref_rx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic bit model_ok(input int n, input logic [31:0] dv);
    if (n < 1 || n > M) return 0;
    for (int i = 0; i < n; i++) if (dv[4*i +: 4] > 4'd9) return 0;
    return 1;
  endfunction

  function automatic logic [7:0] op_char(input logic [1:0] o);
    case (o)
      2'd0: return 8'h2B;
      2'd1: return 8'h2D;
      2'd2: return 8'h2A;
      default: return 8'h2F;
    endcase
  endfunction

  function automatic int char_class(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return 1;
    if (c == 8'h2B || c == 8'h2D || c == 8'h2A || c == 8'h2F) return 2;
    return 0;
  endfunction

  // Drive one load request; expectations come from the model alone.
  task automatic send(input int n, input logic [31:0] dv, input logic [13:0] ov);
    bit ok;
    @(posedge clk); #1;
    count = n[3:0]; digits = dv; ops = ov; start = 1'b1;
    ok = model_ok(n, dv);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back(8'h30 + {4'h0, dv[4*i +: 4]});
        if (i < n - 1) exp_q.push_back(op_char(ov[2*i +: 2]));
      end
      exp_done++;
    end else begin
      exp_err++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (ok) chk("busy_after_start", busy, 1);
    else begin
      chk("err_pulse", err, 1);
      chk("busy_on_reject", busy, 0);
      chk("valid_on_reject", out_valid, 0);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    if (busy) begin
      failures++;
      $display("FAIL wait_idle: busy still 1 after 400 cycles");
    end
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: sampled mid-cycle, reflecting what the next rising edge sees.
  always @(negedge clk) begin
    if (!clr) begin
      if (held) chk("stall_hold", {23'd0, out_valid, out_char}, {23'd0, 1'b1, held_char});
      held = 0;
      if (out_valid && !out_ready) begin
        held = 1;
        held_char = out_char;
      end
      if (out_valid && out_ready) begin
        rx.push_back(out_char);
        if (exp_q.size() == 0) begin
          failures++; checks++;
          $display("FAIL unexpected_char: got %0h expected none", out_char);
        end else begin
          chk("char", out_char, exp_q.pop_front());
        end
        chk("recognizer_class", char_class(out_char), expect_digit ? 1 : 2);
        expect_digit = !expect_digit;
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", exp_q.size(), 0);
        chk("recognizer_end", expect_digit, 0);
        expect_digit = 1;
      end
      if (err) err_cnt++;
    end
  end

  initial begin
    logic [31:0] dv;
    logic [13:0] ov;
    int n;

    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // "5+0*7" with exact latency
    send(3, 32'h0000_0705, 14'b10_00);
    for (int m = 2; m <= 7; m++) begin
      @(posedge clk); #1;
      chk("lat_busy", busy, (m <= 5) ? 1 : 0);
      chk("lat_done", done, (m == 6) ? 1 : 0);
    end

    // single operand
    send(1, 32'h0000_0009, 14'h3FFF);
    wait_idle();

    // rejects
    send(0, 32'h0, 14'h0);
    send(3, 32'h0000_0A00, 14'h0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("reject_no_valid", out_valid, 0);
    end
    send(9, 32'h0, 14'h0);
    send(3, 32'h00F0_0321, 14'b01_11);
    wait_idle();

    // backpressure: same stream with ready high, then random ready
    rx.delete();
    send(4, 32'h0000_8264, 14'b11_01_10);
    wait_idle();
    repeat (2) @(posedge clk);
    ref_rx = rx;
    rx.delete();
    bp_mode = 1;
    send(4, 32'h0000_8264, 14'b11_01_10);
    wait_idle();
    bp_mode = 0;
    repeat (2) @(posedge clk);
    chk("bp_len", rx.size(), ref_rx.size());
    for (int i = 0; i < ref_rx.size() && i < rx.size(); i++)
      chk("bp_byte", rx[i], ref_rx[i]);

    // start while busy is ignored
    send(4, 32'h0000_1357, 14'b00_01_10);
    @(posedge clk); #1;
    digits = 32'h0000_9999; ops = 14'h3FFF; count = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // clr after the 2nd transfer
    send(4, 32'h0000_4321, 14'b10_01_00);
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr_valid_async", out_valid, 0);
    chk("clr_busy_async", busy, 0);
    exp_q.delete();
    exp_done--;
    expect_digit = 1;
    @(posedge clk); #1;
    chk("clr_no_done", done, 0);
    clr = 1'b0;
    send(3, 32'h0000_0246, 14'b11_10);
    wait_idle();

    // randomized streams, some invalid
    for (int s = 0; s < 20; s++) begin
      n = $urandom_range(0, 9);
      for (int i = 0; i < 8; i++)
        dv[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      ov = 14'($urandom);
      bp_mode = $urandom_range(0, 1);
      send(n, dv, ov);
      wait_idle();
      bp_mode = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done);
    chk("err_count", err_cnt, exp_err);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/expr_tx.md
# expr_tx

Transmitter end of the ASCII expression stream checked by the expression-recognizer FSM. It snapshots up to MAX_OPERANDS single-digit operands and the operators between them, then emits the characters digit, op, digit, …, digit, one per accepted handshake, on an 8-bit bus. Every complete stream it sends is a valid expression for that recognizer.

## Interface
- MAX_OPERANDS, default 8: capacity in operands; legal range 2..16.
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  load request; sampled only in IDLE.
- count  in  4  number of operands N to send; legal range 1..MAX_OPERANDS.
- digits  in  4*MAX_OPERANDS  operand i in bits [4i+3:4i], BCD 0..9.
- ops  in  2*(MAX_OPERANDS-1)  operator i in bits [2i+1:2i], placed between operand i and operand i+1.
  - Encoding: 00 '+', 01 '-', 10 '*', 11 '/'.
- out_char  out  8  ASCII character.
- out_valid  out  1  out_char holds a character.
- out_ready  in  1  sink accepts the character.
- busy  out  1  transmission in progress (state is not IDLE).
- done  out  1  one-cycle pulse after the last digit transfers.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
States:
- IDLE
  - On start:
    - Reject if count == 0 or count > MAX_OPERANDS, or if any digits[i] > 9 for i < count.
    - On reject: pulse err next cycle, stay in IDLE, nothing sent.
    - Otherwise: latch digits, ops and count into internal registers, clear index k = 0, go to SEND_DIG.
- SEND_DIG
  - out_valid = 1, out_char = "0" + digit[k].
  - On transfer (out_valid && out_ready):
    - If k == N-1: go to IDLE and pulse done.
    - Otherwise: go to SEND_OP.
- SEND_OP
  - out_valid = 1, out_char = ASCII of op[k].
  - On transfer: k = k+1, go to SEND_DIG.

Rules:
- Latched values only are used during transmission. Changes on digits, ops and count while busy have no effect.
- start while busy is ignored. It is neither queued nor flagged.
- Total characters per stream: 2N-1. N = 1 sends a single digit.
- out_char and out_valid are registered. Both stay stable while out_valid && !out_ready.
- Outputs in IDLE: out_char = 8'h00, out_valid = 0.

## Timing
- Reset values, applied immediately when clr asserts: state IDLE, out_valid 0, out_char 8'h00, busy 0, done 0, err 0, k 0.
- clr mid-stream aborts the stream with no done pulse. The sink observes out_valid fall immediately, without waiting for a clock edge.
- Latency:
  - Start sampled at edge t: out_valid = 1 after edge t, so the first character is visible in cycle t+1.
  - With out_ready held high: one character per cycle. The last character transfers at edge t+2N-1, and done = 1 in the following cycle, together with busy = 0.
- err is asserted in the cycle after the rejected start. busy stays 0 throughout.
- A new start is accepted the cycle done is high, since the block is already in IDLE.
- out_ready is ignored when out_valid = 0.

## Structure
- Shared package holds:
  - state enum: IDLE, SEND_DIG, SEND_OP.
  - operator codes, and the ASCII constants "+", "-", "*", "/", "0".
  - a function op_to_ascii(2-bit) → 8-bit.
- One sub-module, expr_tx_validate: combinational check of count and digit range, producing a single ok bit.
- Datapath:
  - latched operand and operator shift registers, shifted down on each transfer so index k becomes implicit.
  - a remaining-operands counter of 4+ bits.

## Test plan
- count = 3, digits = {7, 0, 5}, ops = {'*', '+'}, out_ready = 1 → the sink receives "5+0*7", i.e. digit0 = 5, op0 = '+', digit1 = 0, op1 = '*', digit2 = 7. done pulses exactly at cycle 6 after start; busy is high for cycles 1..5.
- count = 1, digit0 = 9 → the single character "9", then done; no operator is emitted.
- Backpressure: out_ready toggles pseudo-randomly over a 4-operand stream.
  - out_char is held across every stall.
  - No character is duplicated or dropped.
  - The output byte sequence is identical to the out_ready = 1 run.
- Rejects:
  - count = 0 → err pulse.
  - digit2 = 4'hA with count = 3 → err pulse, out_valid never rises.
  - digit5 = 4'hF with count = 3 → accepted, since the invalid digit is beyond count.
- start pulsed mid-stream with different digits → ignored; the original stream completes unchanged.
- clr asserted after the 2nd transfer → out_valid drops with no clock edge; state returns to IDLE with no done pulse. A fresh start afterward transmits correctly from digit0.
- Feed every output stream into the expression-recognizer FSM → its out is 1 after every digit character and at stream end.
